jk_fsm_bank: RTL and testbench

//  Parametrised bank of CH independent two-state (OFF/ON) J/K control FSMs sharing one clock.

---
 rtl/jk_fsm_bank.sv | 120 ++++++++++++
 tb/tb_jk_fsm_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jk_fsm_bank.sv
// rtl/jk_fsm_bank.sv - bank of independent OFF/ON J/K control FSMs with dwell lockout and transition count
module jk_fsm_bank #(
    parameter int CH       = 4,
    parameter int HOLD_W   = 4,
    parameter int MIN_HOLD = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CH-1:0]    j,
    input  logic [CH-1:0]    k,
    input  logic             clr_cnt,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic [CH-1:0]    locked,
    output logic [CNT_W-1:0] trans_cnt
);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD    = HOLD_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t            state      [CH];
    state_t            state_nxt  [CH];
    logic [HOLD_W-1:0] dwell      [CH];
    logic [HOLD_W-1:0] dwell_nxt  [CH];
    logic [CH-1:0]     want;
    logic [CH-1:0]     rise_nxt;
    logic [CH-1:0]     fall_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= OFF;
                dwell[i] <= '0;
            end
            rise      <= '0;
            fall      <= '0;
            trans_cnt <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= state_nxt[i];
                dwell[i] <= dwell_nxt[i];
            end
            rise      <= rise_nxt;
            fall      <= fall_nxt;
            trans_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        want     = '0;
        rise_nxt = '0;
        fall_nxt = '0;
        cnt_nxt  = trans_cnt;
        for (int i = 0; i < CH; i++) begin
            state_nxt[i] = state[i];
            dwell_nxt[i] = dwell[i];
        end

        if (en) begin
            for (int i = 0; i < CH; i++) begin
                want[i] = (state[i] == ON);
                unique case (mode)
                    2'd0: begin
                        if (j[i] && k[i])
                            want[i] = (state[i] != ON);
                        else if (j[i])
                            want[i] = 1'b1;
                        else if (k[i])
                            want[i] = 1'b0;
                    end
                    2'd1: begin
                        if (j[i])
                            want[i] = 1'b1;
                        else if (k[i])
                            want[i] = 1'b0;
                    end
                    2'd2: begin
                        if (k[i])
                            want[i] = 1'b0;
                        else if (j[i])
                            want[i] = 1'b1;
                    end
                    default: ;
                endcase

                if (dwell[i] != '0) begin
                    dwell_nxt[i] = dwell[i] - 1'b1;
                end else if (want[i] != (state[i] == ON)) begin
                    state_nxt[i] = want[i] ? ON : OFF;
                    dwell_nxt[i] = HOLD;
                    rise_nxt[i]  = want[i];
                    fall_nxt[i]  = ~want[i];
                    // Incrementing one at a time saturates without a wider adder.
                    if (cnt_nxt != CNT_MAX)
                        cnt_nxt = cnt_nxt + 1'b1;
                end
            end
            if (clr_cnt)
                cnt_nxt = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            out[i]    = (state[i] == ON);
            locked[i] = (dwell[i] != '0);
        end
    end

endmodule

// File: tb/tb_jk_fsm_bank.sv
// tb/tb_jk_fsm_bank.sv - randomized check of jk_fsm_bank against a reference model
module tb_jk_fsm_bank;

    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       reset, en, clr_cnt;
    logic [1:0] mode;
    logic [CH-1:0] j, k;
    logic [CH-1:0] out_a, rise_a, fall_a, locked_a;
    logic [CH-1:0] out_b, rise_b, fall_b, locked_b;
    logic [7:0]    cnt_a, cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: instance 0 has a 3-cycle dwell, instance 1 has none.
    int m_hold [2] = '{3, 0};
    int m_on   [2][CH];
    int m_dw   [2][CH];
    int m_rise [2][CH];
    int m_fall [2][CH];
    int m_cnt  [2];

    always #5 clk = ~clk;

    jk_fsm_bank #(.CH(CH), .HOLD_W(4), .MIN_HOLD(3), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .clr_cnt(clr_cnt),
        .out(out_a), .rise(rise_a), .fall(fall_a), .locked(locked_a), .trans_cnt(cnt_a)
    );

    jk_fsm_bank #(.CH(CH), .HOLD_W(4), .MIN_HOLD(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .clr_cnt(clr_cnt),
        .out(out_b), .rise(rise_b), .fall(fall_b), .locked(locked_b), .trans_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            int moves;
            moves = 0;
            for (int c = 0; c < CH; c++) begin
                m_rise[u][c] = 0;
                m_fall[u][c] = 0;
            end
            if (!reset) begin
                for (int c = 0; c < CH; c++) begin
                    m_on[u][c] = 0;
                    m_dw[u][c] = 0;
                end
                m_cnt[u] = 0;
            end else if (en) begin
                for (int c = 0; c < CH; c++) begin
                    int target;
                    target = m_on[u][c];
                    if (mode == 0) begin
                        if (j[c] && k[c]) target = 1 - m_on[u][c];
                        else if (j[c])    target = 1;
                        else if (k[c])    target = 0;
                    end else if (mode == 1) begin
                        if (j[c])      target = 1;
                        else if (k[c]) target = 0;
                    end else if (mode == 2) begin
                        if (k[c])      target = 0;
                        else if (j[c]) target = 1;
                    end
                    if (m_dw[u][c] > 0) begin
                        m_dw[u][c] = m_dw[u][c] - 1;
                    end else if (target != m_on[u][c]) begin
                        m_on[u][c]   = target;
                        m_dw[u][c]   = m_hold[u];
                        m_rise[u][c] = target;
                        m_fall[u][c] = 1 - target;
                        moves++;
                    end
                end
                if (clr_cnt) m_cnt[u] = 0;
                else         m_cnt[u] = (m_cnt[u] + moves > 255) ? 255 : m_cnt[u] + moves;
            end
        end
    endtask

    function automatic logic [CH-1:0] pack(input int u, input int sel);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) begin
            case (sel)
                0:       v[c] = (m_on[u][c] != 0);
                1:       v[c] = (m_rise[u][c] != 0);
                2:       v[c] = (m_fall[u][c] != 0);
                default: v[c] = (m_dw[u][c] != 0);
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_a",    32'(out_a),    32'(pack(0, 0)));
        chk("rise_a",   32'(rise_a),   32'(pack(0, 1)));
        chk("fall_a",   32'(fall_a),   32'(pack(0, 2)));
        chk("locked_a", 32'(locked_a), 32'(pack(0, 3)));
        chk("cnt_a",    32'(cnt_a),    32'(m_cnt[0]));
        chk("out_b",    32'(out_b),    32'(pack(1, 0)));
        chk("rise_b",   32'(rise_b),   32'(pack(1, 1)));
        chk("fall_b",   32'(fall_b),   32'(pack(1, 2)));
        chk("locked_b", 32'(locked_b), 32'(pack(1, 3)));
        chk("cnt_b",    32'(cnt_b),    32'(m_cnt[1]));
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [CH-1:0] jj, input logic [CH-1:0] kk,
                         input logic cc, input int cycles);
        reset = r; en = e; mode = m; j = jj; k = kk; clr_cnt = cc;
        for (int n = 0; n < cycles; n++) tick();
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_cnt[u] = 0;
            for (int c = 0; c < CH; c++) begin
                m_on[u][c] = 0; m_dw[u][c] = 0; m_rise[u][c] = 0; m_fall[u][c] = 0;
            end
        end

        // Reset with all requests asserted, then idle.
        drive(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 2);
        chk("reset_out",   32'(out_a), 32'h0);
        chk("reset_count", 32'(cnt_a), 32'h0);
        drive(1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 2);

        // Single set pulse, then held clear through the lockout.
        drive(1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b0, 1);
        drive(1'b1, 1'b1, 2'd0, 4'h0, 4'h1, 1'b0, 5);
        chk("dwell_pair", 32'(cnt_a), 32'd2);

        // Toggle, then set-dominant, then reset-dominant.
        drive(1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 6);
        drive(1'b1, 1'b1, 2'd1, 4'h1, 4'h1, 1'b0, 6);
        drive(1'b1, 1'b1, 2'd2, 4'h1, 4'h1, 1'b0, 6);
        drive(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 3);

        // Freeze mid-lockout on channel 1, then resume.
        drive(1'b1, 1'b1, 2'd0, 4'h2, 4'h0, 1'b0, 1);
        drive(1'b1, 1'b0, 2'd0, 4'h2, 4'h0, 1'b1, 5);
        chk("frozen_lock", 32'(locked_a[1]), 32'd1);
        drive(1'b1, 1'b1, 2'd0, 4'h2, 4'h0, 1'b0, 5);

        // Drive the counters into saturation, then clear them.
        drive(1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0, 80);
        chk("sat_b", 32'(cnt_b), 32'd255);
        drive(1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 1);
        chk("clr_b", 32'(cnt_b), 32'd0);

        // Reset during a lockout, then a set on channel 2 right after release.
        drive(1'b1, 1'b1, 2'd1, 4'hA, 4'h5, 1'b0, 1);
        drive(1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 1'b0, 1);
        drive(1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 1'b0, 1);
        chk("mid_lock_rst", 32'(locked_a), 32'h0);
        drive(1'b1, 1'b1, 2'd0, 4'h4, 4'h0, 1'b0, 1);
        chk("post_rst_set", 32'(out_a), 32'h4);

        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 49) == 0), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
